// File: rtl/mem_port_arbiter.sv
// Arbitrates the single SRAM-like memory port between instruction fetch and data access.
// Data wins conflicts; each grant is held until mem_ack or timeout, then answered by a 1-cycle done.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_done,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              err,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                discard_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_wstrb_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic busy, ack, tmo, fin, discard;

  // A flush arriving in the same cycle as completion already suppresses the fetch result.
  always_comb begin
    busy         = (state_q != IDLE);
    ack          = busy & mem_ack;
    tmo          = busy & ~mem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
    fin          = ack | tmo;
    discard      = discard_q | ((state_q == BUSY_I) & flush);
    inst_done    = (state_q == BUSY_I) & fin & ~discard;
    data_done    = (state_q == BUSY_D) & fin;
    err          = tmo & (inst_done | data_done);
    inst_rdata   = (inst_done & ack) ? mem_rdata : '0;
    data_rdata   = (data_done & ack) ? mem_rdata : '0;
    stallreq_mem = resetn & data_req & ~data_done;
    stallreq_if  = resetn & inst_req & ~inst_done & ~discard;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          discard_q <= 1'b0;
          if (data_req) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= data_we;
            mem_addr_q  <= data_addr;
            mem_wstrb_q <= data_wstrb;
            mem_wdata_q <= data_wdata;
          end else if (inst_req && !flush) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= inst_addr;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (fin) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (state_q == BUSY_I && flush) discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        resetn, flush, inst_req, data_req, data_we, mem_ack;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;
  logic        inst_done, data_done, err, stallreq_if, stallreq_mem;
  logic        mem_req, mem_we;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata), .err(err),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), busy cycles elapsed, drop flag.
  int          owner = 0;
  int          age   = 0;
  bit          drop  = 0;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          lat_tgt   = 0;
  int          lat_fixed = 0;
  bit          rand_lat  = 0;
  bit          idle_ack  = 0;
  bit          x_idone, x_ddone, x_fin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ackv, tmo, dropeff, eerr, esi, esm;
    logic [31:0] eir, edr;
    ackv    = (owner != 0) && mem_ack;
    tmo     = (owner != 0) && !mem_ack && (age == TO - 1);
    x_fin   = resetn && (ackv || tmo);
    dropeff = drop || (owner == 1 && flush);
    x_idone = x_fin && owner == 1 && !dropeff;
    x_ddone = x_fin && owner == 2;
    eerr    = tmo && (x_idone || x_ddone);
    eir     = (x_idone && ackv) ? mem_rdata : 32'h0;
    edr     = (x_ddone && ackv) ? mem_rdata : 32'h0;
    esm     = resetn && data_req && !x_ddone;
    esi     = resetn && inst_req && !x_idone && !dropeff;
    chk("inst_done", inst_done, x_idone);
    chk("data_done", data_done, x_ddone);
    chk("err", err, eerr);
    chk("inst_rdata", inst_rdata, eir);
    chk("data_rdata", data_rdata, edr);
    chk("stallreq_if", stallreq_if, esi);
    chk("stallreq_mem", stallreq_mem, esm);
    chk("mem_req", mem_req, resetn && owner != 0);
    if (!resetn) begin
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end else if (owner != 0) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wstrb", mem_wstrb, m_wstrb);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic model_edge();
    if (!resetn) begin
      owner = 0; age = 0; drop = 0;
    end else if (owner == 0) begin
      age = 0; drop = 0;
      lat_tgt = rand_lat ? int'($urandom_range(0, TO + 1)) : lat_fixed;
      if (data_req) begin
        owner = 2; m_we = data_we; m_addr = data_addr; m_wstrb = data_wstrb; m_wdata = data_wdata;
      end else if (inst_req && !flush) begin
        owner = 1; m_we = 0; m_addr = inst_addr; m_wstrb = 4'h0; m_wdata = 32'h0;
      end
    end else if (x_fin) begin
      owner = 0; age = 0; drop = 0;
    end else begin
      if (owner == 1 && flush) drop = 1;
      age++;
    end
  endtask

  // One clock: memory responds, outputs checked at negedge, model advances at posedge.
  task automatic step();
    mem_ack   = resetn && ((owner != 0 && age == lat_tgt) || (owner == 0 && idle_ack));
    mem_rdata = $urandom();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    if (x_ddone) data_req = 0;
    if (x_idone) inst_req = 0;
  endtask

  initial begin
    resetn = 0; flush = 0; inst_req = 0; data_req = 0; data_we = 0; mem_ack = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0; mem_rdata = 0;
    repeat (2) step();
    resetn = 1;
    step();

    // Single fetch, ack in the 4th busy cycle
    inst_req = 1; inst_addr = 32'hBFC0_0000; lat_fixed = 3;
    repeat (7) step();

    // Conflict: store wins, fetch follows
    inst_req = 1; inst_addr = 32'h0000_2000; lat_fixed = 1;
    data_req = 1; data_we = 1; data_addr = 32'h100; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
    repeat (8) step();

    // Zero-wait back-to-back fetches
    lat_fixed = 0;
    for (int i = 0; i < 8; i++) begin
      if (!inst_req) begin inst_req = 1; inst_addr = 32'h1000 + 4 * i; end
      step();
    end
    inst_req = 0;
    step();

    // Timeout, then a late ack in IDLE
    inst_req = 1; inst_addr = 32'h3000; lat_fixed = 100;
    repeat (10) step();
    idle_ack = 1;
    repeat (2) step();
    idle_ack = 0;

    // Flush during BUSY_I, then redirected fetch
    inst_req = 1; inst_addr = 32'h4000; lat_fixed = 4;
    repeat (2) step();
    flush = 1; inst_addr = 32'h5000;
    step();
    flush = 0; lat_fixed = 1;
    repeat (10) step();

    // Reset asserted during BUSY_D
    data_req = 1; data_we = 0; data_addr = 32'h200; data_wstrb = 4'h0; lat_fixed = 5;
    repeat (3) step();
    resetn = 0;
    #1;
    check_all();
    repeat (2) step();
    resetn = 1; data_req = 0;
    repeat (3) step();

    // Randomized traffic
    rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      if (!data_req && $urandom_range(0, 3) == 0) begin
        data_req = 1; data_we = 1'($urandom_range(0, 1)); data_addr = $urandom();
        data_wstrb = 4'($urandom()); data_wdata = $urandom();
      end
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom();
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush && inst_req) inst_addr = $urandom();
      idle_ack = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
